pipe_ctrl: RTL and testbench

Pipeline controller for the 3-stage RISC-V core. It turns execute-stage jump requests and stall sources (divider busy, instruction-bus wait) into hold and flush controls for the PC register, the `if_id` register and the `id_ex` register. A jump that arrives during a stall is buffered and replayed when the stall ends. A watchdog converts an over-long bus wait into a trap redirect.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/hold_wdt.sv | 46 ++++
 rtl/pipe_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared definitions for the pipeline controller
//
// Contents:
//   pc_state_e     controller FSM encodings (PC_RUN, PC_HOLD, PC_PEND)
//   DEF_TRAP_ADDR  default redirect target on instruction-bus timeout
//   INST_NOP       encoding loaded into if_id when it is flushed (addi x0,x0,0)
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_RUN  = 2'd0,
        PC_HOLD = 2'd1,
        PC_PEND = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEF_TRAP_ADDR = 32'h0000_0100;
    localparam logic [31:0] INST_NOP      = 32'h0000_0013;

endpackage

// File: rtl/hold_wdt.sv
// rtl/hold_wdt.sv - instruction-bus wait watchdog
//
// Counts consecutive cycles of hold_bus and flags the cycle in which the
// BUS_TIMEOUT-th consecutive wait cycle occurs.
//
// Parameters:
//   BUS_TIMEOUT  consecutive hold_bus cycles that cause a timeout (2..255)
// Ports:
//   sys_clk    in   clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   hold_bus   in   instruction bus not ready
//   tmo        out  this cycle is the timeout cycle (combinational)
module hold_wdt #(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic hold_bus,
    output logic tmo
);

    localparam logic [7:0] WD_LAST = 8'(BUS_TIMEOUT - 1);

    logic [7:0] wd_cnt_q;
    logic [7:0] wd_cnt_d;

    assign tmo = hold_bus && (wd_cnt_q == WD_LAST);

    // The counter restarts after a timeout so a bus that stays stuck
    // produces a fresh trap every BUS_TIMEOUT cycles.
    always_comb begin
        wd_cnt_d = 8'd0;
        if (hold_bus && !tmo) begin
            wd_cnt_d = wd_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wd_cnt_q <= 8'd0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - hold/flush/redirect controller for the 3-stage pipeline
//
// Optional feature: define PIPE_CTRL_STATS_EN to build the saturating
// stall_cnt / flush_cnt statistics counters; otherwise both read 0.
//
// Parameters:
//   BUS_TIMEOUT    consecutive hold_bus cycles that trigger a trap (2..255)
//   TRAP_ADDR      redirect target on bus timeout
// Ports:
//   sys_clk, sys_rst_n         clock / asynchronous active-low reset
//   jump_en, jump_addr         redirect request from EX
//   hold_div, hold_bus         stall sources (divider busy, bus wait)
//   hold_pc, hold_ifid         keep PC / if_id
//   flush_ifid, flush_idex     bubble if_id / id_ex
//   jump_out_en, jump_out_addr PC redirect
//   bus_err                    one-cycle bus timeout pulse
//   stall_cnt, flush_cnt       statistics counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          BUS_TIMEOUT = 16,
    parameter logic [31:0] TRAP_ADDR   = DEF_TRAP_ADDR
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    input  logic        hold_div,
    input  logic        hold_bus,
    output logic        hold_pc,
    output logic        hold_ifid,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        jump_out_en,
    output logic [31:0] jump_out_addr,
    output logic        bus_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    pc_state_e   state_q, state_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic        hold;
    logic        tmo;

    assign hold = hold_div | hold_bus;

    hold_wdt #(
        .BUS_TIMEOUT (BUS_TIMEOUT)
    ) u_hold_wdt (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .hold_bus  (hold_bus),
        .tmo       (tmo)
    );

    always_comb begin
        state_d       = state_q;
        pend_addr_d   = pend_addr_q;
        hold_pc       = 1'b0;
        hold_ifid     = 1'b0;
        flush_ifid    = 1'b0;
        flush_idex    = 1'b0;
        jump_out_en   = 1'b0;
        jump_out_addr = 32'd0;
        bus_err       = 1'b0;

        if (tmo) begin
            // Trap redirect overrides everything; a pending jump is dropped
            // simply by leaving PEND.
            bus_err       = 1'b1;
            jump_out_en   = 1'b1;
            jump_out_addr = TRAP_ADDR;
            flush_ifid    = 1'b1;
            flush_idex    = 1'b1;
            state_d       = PC_RUN;
        end else begin
            unique case (state_q)
                PC_PEND: begin
                    if (hold) begin
                        hold_pc   = 1'b1;
                        hold_ifid = 1'b1;
                    end else begin
                        // Replay the captured target; a live jump_en here is
                        // younger than the captured one and is discarded.
                        jump_out_en   = 1'b1;
                        jump_out_addr = pend_addr_q;
                        flush_ifid    = 1'b1;
                        flush_idex    = 1'b1;
                        state_d       = PC_RUN;
                    end
                end
                PC_HOLD: begin
                    if (hold) begin
                        hold_pc   = 1'b1;
                        hold_ifid = 1'b1;
                        if (jump_en) begin
                            pend_addr_d = jump_addr;
                            state_d     = PC_PEND;
                        end
                    end else begin
                        // Stall released: behave exactly as RUN this cycle.
                        state_d = PC_RUN;
                        if (jump_en) begin
                            jump_out_en   = 1'b1;
                            jump_out_addr = jump_addr;
                            flush_ifid    = 1'b1;
                            flush_idex    = 1'b1;
                        end
                    end
                end
                default: begin
                    if (jump_en) begin
                        jump_out_en   = 1'b1;
                        jump_out_addr = jump_addr;
                        flush_ifid    = 1'b1;
                        flush_idex    = 1'b1;
                        state_d       = PC_RUN;
                    end else if (hold) begin
                        hold_pc   = 1'b1;
                        hold_ifid = 1'b1;
                        state_d   = PC_HOLD;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= PC_RUN;
            pend_addr_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
        end
    end

`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hold_pc && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (jump_out_en && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl (BUS_TIMEOUT=4)
module tb_pipe_ctrl;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        hold_div;
    logic        hold_bus;
    logic        hold_pc;
    logic        hold_ifid;
    logic        flush_ifid;
    logic        flush_idex;
    logic        jump_out_en;
    logic [31:0] jump_out_addr;
    logic        bus_err;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int checks   = 0;
    int failures = 0;

    pipe_ctrl #(
        .BUS_TIMEOUT (4),
        .TRAP_ADDR   (32'h0000_0100)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .jump_en       (jump_en),
        .jump_addr     (jump_addr),
        .hold_div      (hold_div),
        .hold_bus      (hold_bus),
        .hold_pc       (hold_pc),
        .hold_ifid     (hold_ifid),
        .flush_ifid    (flush_ifid),
        .flush_idex    (flush_idex),
        .jump_out_en   (jump_out_en),
        .jump_out_addr (jump_out_addr),
        .bus_err       (bus_err),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        je;
        logic [31:0] ja;
        logic        hd;
        logic        hb;
        logic        hp;   // expected hold_pc and hold_ifid
        logic        fl;   // expected flush_ifid and flush_idex
        logic        jo;
        logic [31:0] joa;
        logic        be;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic je, logic [31:0] ja, logic hd, logic hb,
                                logic hp, logic fl, logic jo, logic [31:0] joa, logic be);
        vec_t v;
        v.je = je; v.ja = ja; v.hd = hd; v.hb = hb;
        v.hp = hp; v.fl = fl; v.jo = jo; v.joa = joa; v.be = be;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(string tag, vec_t v);
        chk({tag, " hold_pc"},       {31'd0, hold_pc},     {31'd0, v.hp});
        chk({tag, " hold_ifid"},     {31'd0, hold_ifid},   {31'd0, v.hp});
        chk({tag, " flush_ifid"},    {31'd0, flush_ifid},  {31'd0, v.fl});
        chk({tag, " flush_idex"},    {31'd0, flush_idex},  {31'd0, v.fl});
        chk({tag, " jump_out_en"},   {31'd0, jump_out_en}, {31'd0, v.jo});
        chk({tag, " jump_out_addr"}, jump_out_addr,        v.joa);
        chk({tag, " bus_err"},       {31'd0, bus_err},     {31'd0, v.be});
    endtask

    // Drive one cycle's inputs just after a rising edge, check at the falling edge.
    task automatic apply(string tag, vec_t v);
        jump_en   = v.je;
        jump_addr = v.ja;
        hold_div  = v.hd;
        hold_bus  = v.hb;
        @(negedge sys_clk);
        chk_outs(tag, v);
        @(posedge sys_clk);
        #1;
    endtask

    vec_t idle;
    int   stall_model;
    int   flush_model;
    logic [31:0] exp_stall;
    logic [31:0] exp_flush;

    initial begin
        idle = mk(0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0);

        // idle / live jump
        vecs.push_back(idle);
        vecs.push_back(mk(1, 32'h80,  0, 0, 0, 1, 1, 32'h80,  0));
        vecs.push_back(idle);
        // deferred jump: first capture wins, replay after hold drops
        vecs.push_back(mk(0, 32'h0,   1, 0, 1, 0, 0, 32'h0,   0));
        vecs.push_back(mk(1, 32'h200, 1, 0, 1, 0, 0, 32'h0,   0));
        vecs.push_back(mk(1, 32'h300, 1, 0, 1, 0, 0, 32'h0,   0));
        vecs.push_back(mk(0, 32'h0,   0, 0, 0, 1, 1, 32'h200, 0));
        vecs.push_back(idle);
        // jump beats a same-cycle hold in RUN
        vecs.push_back(mk(1, 32'h44,  1, 0, 0, 1, 1, 32'h44,  0));
        vecs.push_back(idle);
        // HOLD released with a live jump: RUN rules apply
        vecs.push_back(mk(0, 32'h0,   1, 0, 1, 0, 0, 32'h0,   0));
        vecs.push_back(mk(1, 32'h58,  0, 0, 0, 1, 1, 32'h58,  0));
        vecs.push_back(idle);
        // PEND replay ignores the live jump
        vecs.push_back(mk(0, 32'h0,   1, 0, 1, 0, 0, 32'h0,   0));
        vecs.push_back(mk(1, 32'h600, 1, 0, 1, 0, 0, 32'h0,   0));
        vecs.push_back(mk(1, 32'h700, 0, 0, 0, 1, 1, 32'h600, 0));
        vecs.push_back(idle);
        // bus timeout: 6 cycles of hold_bus
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 32'h0, 0, 1, 1, 0, 0, 32'h0, 0));
        vecs.push_back(mk(0, 32'h0,   0, 1, 0, 1, 1, 32'h100, 1));
        for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 32'h0, 0, 1, 1, 0, 0, 32'h0, 0));
        vecs.push_back(idle);
        // timeout discards a pending jump
        vecs.push_back(mk(0, 32'h0,   0, 1, 1, 0, 0, 32'h0,   0));
        vecs.push_back(mk(1, 32'h900, 0, 1, 1, 0, 0, 32'h0,   0));
        vecs.push_back(mk(0, 32'h0,   0, 1, 1, 0, 0, 32'h0,   0));
        vecs.push_back(mk(0, 32'h0,   0, 1, 0, 1, 1, 32'h100, 1));
        vecs.push_back(idle);
        // counter clear: 3 on, 1 off, 3 on
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 32'h0, 0, 1, 1, 0, 0, 32'h0, 0));
        vecs.push_back(idle);
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 32'h0, 0, 1, 1, 0, 0, 32'h0, 0));
        vecs.push_back(idle);
        // hold_div alone clears the watchdog
        for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 32'h0, 0, 1, 1, 0, 0, 32'h0, 0));
        vecs.push_back(mk(0, 32'h0,   1, 0, 1, 0, 0, 32'h0,   0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 32'h0, 0, 1, 1, 0, 0, 32'h0, 0));
        vecs.push_back(idle);

        // reset state
        sys_rst_n = 1'b0;
        jump_en   = 1'b0;
        jump_addr = 32'h0;
        hold_div  = 1'b0;
        hold_bus  = 1'b0;
        #2;
        chk_outs("reset", idle);
        chk("reset stall_cnt", stall_cnt, 32'd0);
        chk("reset flush_cnt", flush_cnt, 32'd0);
        #10 sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;

        stall_model = 0;
        flush_model = 0;
        foreach (vecs[i]) begin
            apply($sformatf("vec%0d", i), vecs[i]);
            stall_model += int'(vecs[i].hp);
            flush_model += int'(vecs[i].jo);
        end

`ifdef PIPE_CTRL_STATS_EN
        exp_stall = 32'(stall_model);
        exp_flush = 32'(flush_model);
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        chk("table stall_cnt", stall_cnt, exp_stall);
        chk("table flush_cnt", flush_cnt, exp_flush);

        // asynchronous reset while a jump is pending
        apply("pre_rst hold", mk(0, 32'h0,   1, 0, 1, 0, 0, 32'h0, 0));
        apply("pre_rst cap",  mk(1, 32'hABC, 1, 0, 1, 0, 0, 32'h0, 0));
        jump_en   = 1'b0;
        jump_addr = 32'h0;
        hold_div  = 1'b0;
        hold_bus  = 1'b0;
        #2 sys_rst_n = 1'b0;
        #1;
        chk_outs("in_rst", idle);
        chk("in_rst stall_cnt", stall_cnt, 32'd0);
        chk("in_rst flush_cnt", flush_cnt, 32'd0);
        @(negedge sys_clk);
        #1 sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        apply("post_rst idle", idle);
        apply("post_rst idle2", idle);

        // statistics: 5 hold cycles plus 2 jumps from a fresh reset
        for (int i = 0; i < 5; i++) apply($sformatf("stat hold%0d", i), mk(0, 32'h0, 1, 0, 1, 0, 0, 32'h0, 0));
        apply("stat release", idle);
        apply("stat jump0", mk(1, 32'h1000, 0, 0, 0, 1, 1, 32'h1000, 0));
        apply("stat jump1", mk(1, 32'h2000, 0, 0, 0, 1, 1, 32'h2000, 0));
        @(negedge sys_clk);
`ifdef PIPE_CTRL_STATS_EN
        exp_stall = 32'd5;
        exp_flush = 32'd2;
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        chk("stat stall_cnt", stall_cnt, exp_stall);
        chk("stat flush_cnt", flush_cnt, exp_flush);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
